// File: rtl/acc_multichannel.sv
// acc_multichannel: interleaved multi-channel signed accumulator with flush and 2-entry output FIFO
// Ports:
//   clk, aclr (async, active-low)          clock and reset
//   cfg_count                              samples per result (0 -> 1, >MAX_COUNT -> MAX_COUNT)
//   flush                                  pulse: emit every non-empty partial sum
//   in_valid/in_rdy/in_ch/in_data          sample input handshake
//   out_valid/out_rdy/out_ch/out_cnt/out_data  result output handshake (FIFO head)
//   out_sat                                sticky saturation flag (only with ACC_MULTICHANNEL_SAT_EN)
//   busy                                   flush sequencer active
// Build option: define ACC_MULTICHANNEL_SAT_EN for saturating adds and the out_sat port.
module acc_multichannel #(
  parameter int DATA_W    = 32,
  parameter int SUM_W     = 40,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = 2,
  parameter int MAX_COUNT = 16,
  parameter int CNT_W     = 5
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic [CNT_W-1:0]        cfg_count,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_rdy,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic [CH_W-1:0]         out_ch,
  output logic [CNT_W-1:0]        out_cnt,
`ifdef ACC_MULTICHANNEL_SAT_EN
  output logic                    out_sat,
`endif
  output logic signed [SUM_W-1:0] out_data,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [CH_W-1:0] idx, idx_nx;
  logic signed [SUM_W-1:0] sum [CHANNELS];
  logic [CNT_W-1:0] cnt [CHANNELS];
  logic [CH_W-1:0] f_ch [2];
  logic [CNT_W-1:0] f_cnt [2];
  logic signed [SUM_W-1:0] f_sum [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] fill;
  logic [CNT_W-1:0] eff, acc_cnt, push_cnt;
  logic [CH_W-1:0] push_ch;
  logic signed [SUM_W-1:0] ext, base, acc_sum, push_sum;
  logic acc, done_acc, scan_push, push, pop, last;
`ifdef ACC_MULTICHANNEL_SAT_EN
  logic sat [CHANNELS];
  logic f_sat [2];
  logic [SUM_W:0] wide;
  logic ovf, acc_sat, push_sat;
`endif

  assign eff = (cfg_count == '0) ? CNT_W'(1)
             : (32'(cfg_count) > MAX_COUNT) ? CNT_W'(MAX_COUNT) : cfg_count;
  assign in_rdy = aclr & (state == IDLE) & (fill != 2'd2);
  // Out-of-range channels are handshaken but never touch channel state.
  assign acc = in_valid & in_rdy & (32'(in_ch) < CHANNELS);
  assign ext = SUM_W'(in_data);
  // A channel with cnt==0 restarts, so its stale sum is ignored.
  assign base = (cnt[in_ch] == '0) ? '0 : sum[in_ch];
  assign acc_cnt = cnt[in_ch] + CNT_W'(1);
  // ">=" so a channel already past a lowered cfg_count completes on its next sample.
  assign done_acc = acc & (acc_cnt >= eff);
  assign last = (32'(idx) == CHANNELS - 1);
  assign scan_push = (state == SCAN) & (cnt[idx] != '0) & (fill != 2'd2);
  // Scan pushes only happen outside IDLE, when no sample can be accepted: at most one push per cycle.
  assign push = done_acc | scan_push;
  assign push_ch = scan_push ? idx : in_ch;
  assign push_cnt = scan_push ? cnt[idx] : acc_cnt;
  assign push_sum = scan_push ? sum[idx] : acc_sum;
  assign out_valid = fill != 2'd0;
  assign pop = out_valid & out_rdy;
  assign out_ch = f_ch[rd_ptr];
  assign out_cnt = f_cnt[rd_ptr];
  assign out_data = f_sum[rd_ptr];
  assign busy = state != IDLE;

`ifdef ACC_MULTICHANNEL_SAT_EN
  // One guard bit detects signed overflow; clamp toward the sign of the true result.
  assign wide = {base[SUM_W-1], base} + {ext[SUM_W-1], ext};
  assign ovf = wide[SUM_W] ^ wide[SUM_W-1];
  assign acc_sum = !ovf ? wide[SUM_W-1:0]
                 : wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  assign acc_sat = ((cnt[in_ch] != '0) & sat[in_ch]) | ovf;
  assign push_sat = scan_push ? sat[idx] : acc_sat;
  assign out_sat = f_sat[rd_ptr];
`else
  assign acc_sum = base + ext;
`endif

  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      IDLE: if (flush) begin
        state_nx = SCAN;
        idx_nx = '0;
      end
      // Empty channels are skipped; a non-empty one waits for FIFO room.
      SCAN: if ((cnt[idx] == '0) || (fill != 2'd2)) begin
        idx_nx = idx + CH_W'(1);
        state_nx = last ? DONE : SCAN;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        sum[i] <= '0;
        cnt[i] <= '0;
`ifdef ACC_MULTICHANNEL_SAT_EN
        sat[i] <= 1'b0;
`endif
      end
      for (int i = 0; i < 2; i++) begin
        f_ch[i] <= '0;
        f_cnt[i] <= '0;
        f_sum[i] <= '0;
`ifdef ACC_MULTICHANNEL_SAT_EN
        f_sat[i] <= 1'b0;
`endif
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      fill <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      if (acc) begin
        sum[in_ch] <= acc_sum;
        cnt[in_ch] <= done_acc ? '0 : acc_cnt;
`ifdef ACC_MULTICHANNEL_SAT_EN
        sat[in_ch] <= acc_sat;
`endif
      end
      if (scan_push) cnt[idx] <= '0;
      if (push) begin
        f_ch[wr_ptr] <= push_ch;
        f_cnt[wr_ptr] <= push_cnt;
        f_sum[wr_ptr] <= push_sum;
`ifdef ACC_MULTICHANNEL_SAT_EN
        f_sat[wr_ptr] <= push_sat;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fill <= fill + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_acc_multichannel.sv
// tb_acc_multichannel: directed self-checking bench for acc_multichannel (default build)
module tb_acc_multichannel;
  logic clk = 1'b0;
  logic aclr = 1'b1;
  logic [4:0] cfg_count = 5'd1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_rdy;
  logic [1:0] in_ch = '0;
  logic signed [31:0] in_data = '0;
  logic out_valid;
  logic out_rdy = 1'b1;
  logic [1:0] out_ch;
  logic [4:0] out_cnt;
  logic signed [39:0] out_data;
  logic busy;
  int vectors = 0;
  int miscompares = 0;

  acc_multichannel dut (
    .clk(clk), .aclr(aclr), .cfg_count(cfg_count), .flush(flush),
    .in_valid(in_valid), .in_rdy(in_rdy), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_rdy(out_rdy), .out_ch(out_ch), .out_cnt(out_cnt),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input int d);
    int n = 0;
    in_valid = 1'b1;
    in_ch = ch;
    in_data = d;
    while (!in_rdy && n < 50) begin
      step();
      n++;
    end
    chk("send_wait", 64'(n < 50), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic res(input string tag, input int ch, input int c, input longint d);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ch"}, out_ch, ch);
    chk({tag, "_cnt"}, out_cnt, c);
    chk({tag, "_data"}, out_data, d);
  endtask

  initial begin
    int n;
    int seen;
    #2 aclr = 1'b0;
    step();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    aclr = 1'b1;
    step();
    chk("post_rst_in_rdy", in_rdy, 1);

    cfg_count = 5'd4;
    send(2'd0, 100);
    send(2'd0, 200);
    send(2'd0, -50);
    chk("t1_not_yet", out_valid, 0);
    send(2'd0, 7);
    res("t1", 0, 4, 257);
    step();
    chk("t1_drained", out_valid, 0);

    cfg_count = 5'd2;
    send(2'd1, 5);
    send(2'd2, 10);
    send(2'd1, 6);
    res("t2a", 1, 2, 11);
    send(2'd2, -20);
    res("t2b", 2, 2, -10);
    step();
    chk("t2_drained", out_valid, 0);

    out_rdy = 1'b0;
    cfg_count = 5'd1;
    send(2'd0, 1);
    send(2'd1, 2);
    chk("t3_full_rdy", in_rdy, 0);
    res("t3_head0", 0, 1, 1);
    in_valid = 1'b1;
    in_ch = 2'd2;
    in_data = 3;
    step();
    chk("t3_still_full", in_rdy, 0);
    chk("t3_hold_data", out_data, 1);
    out_rdy = 1'b1;
    step();
    res("t3_head1", 1, 1, 2);
    chk("t3_rdy_back", in_rdy, 1);
    step();
    in_valid = 1'b0;
    res("t3_head2", 2, 1, 3);
    step();
    chk("t3_drained", out_valid, 0);

    cfg_count = 5'd8;
    send(2'd0, 3);
    send(2'd3, 4);
    send(2'd3, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_busy_scan", busy, 1);
    chk("t4_rdy_scan", in_rdy, 0);
    step();
    res("t4a", 0, 1, 3);
    step();
    chk("t4_gap", out_valid, 0);
    step();
    chk("t4_busy_mid", busy, 1);
    step();
    res("t4b", 3, 2, 9);
    chk("t4_busy_done", busy, 1);
    chk("t4_rdy_done", in_rdy, 0);
    step();
    chk("t4_busy_idle", busy, 0);
    chk("t4_rdy_idle", in_rdy, 1);
    chk("t4_drained", out_valid, 0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    seen = 0;
    while (busy && n < 20) begin
      n++;
      if (out_valid) seen++;
      step();
    end
    chk("t5_empty_flush_cycles", n, 5);
    chk("t5_empty_flush_outputs", seen, 0);

    cfg_count = 5'd0;
    send(2'd2, 42);
    res("t6_cfg0", 2, 1, 42);
    step();
    cfg_count = 5'd31;
    for (int i = 0; i < 15; i++) send(2'd1, i);
    chk("t6_cfg_over_pending", out_valid, 0);
    send(2'd1, 15);
    res("t6_cfg_clamp", 1, 16, 120);
    step();

    cfg_count = 5'd8;
    send(2'd3, 1);
    send(2'd3, 2);
    send(2'd3, 3);
    cfg_count = 5'd2;
    send(2'd3, 4);
    res("t7_cfg_lower", 3, 4, 10);
    step();

    out_rdy = 1'b0;
    cfg_count = 5'd1;
    send(2'd1, 99);
    cfg_count = 5'd8;
    send(2'd0, 11);
    send(2'd0, 22);
    aclr = 1'b0;
    #1;
    chk("t8_rst_valid", out_valid, 0);
    chk("t8_rst_data", out_data, 0);
    chk("t8_rst_ch", out_ch, 0);
    chk("t8_rst_cnt", out_cnt, 0);
    chk("t8_rst_rdy", in_rdy, 0);
    chk("t8_rst_busy", busy, 0);
    step();
    aclr = 1'b1;
    out_rdy = 1'b1;
    cfg_count = 5'd1;
    step();
    send(2'd0, -5);
    res("t8_restart", 0, 1, -5);
    step();
    chk("t8_drained", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
